// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit.
// Issues in-order fetch requests, remembers each accepted address in an
// in-flight FIFO, and pairs responses with those addresses in a decode queue.
// A credit check (in flight + queued < depth) guarantees that a queue push
// never meets a full queue. A redirect flushes the queue and marks every
// outstanding response as stale so that it is dropped when it arrives.
module unidade_busca #(
  parameter int unsigned        LARGURA      = 32,
  parameter int unsigned        PROFUNDIDADE = 4,
  parameter logic [LARGURA-1:0] PC_RESET     = {LARGURA{1'b0}},
  parameter int unsigned        PASSO        = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          mem_req,
  output logic [LARGURA-1:0]            mem_addr,
  input  logic                          mem_ready,
  input  logic                          mem_valid,
  input  logic [LARGURA-1:0]            mem_data,
  input  logic                          desvio,
  input  logic [LARGURA-1:0]            desvio_alvo,
  input  logic                          parada,
  output logic                          id_valid,
  output logic [LARGURA-1:0]            id_pc,
  output logic [LARGURA-1:0]            id_inst,
  output logic [$clog2(PROFUNDIDADE):0] ocupacao
);

  localparam int unsigned        PW     = $clog2(PROFUNDIDADE);
  localparam int unsigned        CW     = PW + 1;
  localparam logic [CW:0]        LIMITE = (CW + 1)'(PROFUNDIDADE);
  localparam logic [LARGURA-1:0] INCR   = LARGURA'(PASSO);

  logic [LARGURA-1:0] pc_q, pc_d;
  logic [CW-1:0]      em_voo_q, em_voo_d;
  logic [CW-1:0]      descartar_q, descartar_d;
  logic [CW-1:0]      ocupacao_q, ocupacao_d;
  logic [PW-1:0]      voo_wr_q, voo_wr_d, voo_rd_q, voo_rd_d;
  logic [PW-1:0]      fila_wr_q, fila_wr_d, fila_rd_q, fila_rd_d;

  logic [LARGURA-1:0] voo_addr_q  [PROFUNDIDADE];
  logic [LARGURA-1:0] fila_pc_q   [PROFUNDIDADE];
  logic [LARGURA-1:0] fila_inst_q [PROFUNDIDADE];

  logic [CW:0] soma_s;
  logic        aceita_s, resp_s, descarta_s, push_s, pop_s;

  // Head-of-queue outputs; forced idle while reset is held.
  always_comb begin
    id_valid = !reset && (ocupacao_q != {CW{1'b0}});
    mem_addr = pc_q;
    if (id_valid) begin
      id_pc   = fila_pc_q[fila_rd_q];
      id_inst = fila_inst_q[fila_rd_q];
    end else begin
      id_pc   = {LARGURA{1'b0}};
      id_inst = {LARGURA{1'b0}};
    end
    if (reset) begin
      ocupacao = {CW{1'b0}};
    end else begin
      ocupacao = ocupacao_q;
    end
  end

  // Handshake strobes: credit-gated request, response classification, consume.
  always_comb begin
    soma_s     = {1'b0, em_voo_q} + {1'b0, ocupacao_q};
    mem_req    = !reset && !desvio && (soma_s < LIMITE);
    aceita_s   = mem_req && mem_ready;
    resp_s     = !reset && mem_valid && (em_voo_q != {CW{1'b0}});
    descarta_s = resp_s && (descartar_q != {CW{1'b0}});
    push_s     = resp_s && !desvio && (descartar_q == {CW{1'b0}});
    pop_s      = id_valid && !parada && !desvio;
  end

  // Next-state: redirect overrides push, pop and request in the same cycle.
  always_comb begin
    pc_d        = pc_q;
    em_voo_d    = em_voo_q;
    descartar_d = descartar_q;
    ocupacao_d  = ocupacao_q;
    voo_wr_d    = voo_wr_q;
    voo_rd_d    = voo_rd_q + PW'(resp_s);
    fila_wr_d   = fila_wr_q;
    fila_rd_d   = fila_rd_q;
    if (desvio) begin
      // A response in this cycle is dropped; everything still out is stale.
      pc_d        = desvio_alvo;
      em_voo_d    = em_voo_q - CW'(resp_s);
      descartar_d = em_voo_q - CW'(resp_s);
      ocupacao_d  = {CW{1'b0}};
      fila_wr_d   = {PW{1'b0}};
      fila_rd_d   = {PW{1'b0}};
    end else begin
      if (aceita_s) begin
        pc_d     = pc_q + INCR;
        voo_wr_d = voo_wr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        pc_d     = pc_q;
        voo_wr_d = voo_wr_q;
      end
      if (descarta_s) begin
        descartar_d = descartar_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        descartar_d = descartar_q;
      end
      em_voo_d   = em_voo_q + CW'(aceita_s) - CW'(resp_s);
      ocupacao_d = ocupacao_q + CW'(push_s) - CW'(pop_s);
      fila_wr_d  = fila_wr_q + PW'(push_s);
      fila_rd_d  = fila_rd_q + PW'(pop_s);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= PC_RESET;
      em_voo_q    <= {CW{1'b0}};
      descartar_q <= {CW{1'b0}};
      ocupacao_q  <= {CW{1'b0}};
      voo_wr_q    <= {PW{1'b0}};
      voo_rd_q    <= {PW{1'b0}};
      fila_wr_q   <= {PW{1'b0}};
      fila_rd_q   <= {PW{1'b0}};
    end else begin
      pc_q        <= pc_d;
      em_voo_q    <= em_voo_d;
      descartar_q <= descartar_d;
      ocupacao_q  <= ocupacao_d;
      voo_wr_q    <= voo_wr_d;
      voo_rd_q    <= voo_rd_d;
      fila_wr_q   <= fila_wr_d;
      fila_rd_q   <= fila_rd_d;
    end
  end

  // Storage arrays; contents are only visible through valid pointers.
  always_ff @(posedge clock) begin
    if (aceita_s) begin
      voo_addr_q[voo_wr_q] <= pc_q;
    end
    if (push_s) begin
      fila_pc_q[fila_wr_q]   <= voo_addr_q[voo_rd_q];
      fila_inst_q[fila_wr_q] <= mem_data;
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: queue-based reference model plus directed
// literal checks and a randomized run with redirects, stalls and resets.
module tb_unidade_busca;

  localparam int P = 4;
  localparam logic [31:0] PCR = 32'h0000_0000;
  localparam logic [31:0] PASSO_M = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        desvio = 1'b0;
  logic [31:0] desvio_alvo = 32'h0;
  logic        parada = 1'b0;
  logic        mem_req, id_valid;
  logic [31:0] mem_addr, id_pc, id_inst;
  logic [2:0]  ocupacao;

  logic        mem_req2, id_valid2;
  logic [31:0] mem_addr2, id_pc2, id_inst2;
  logic [2:0]  ocupacao2;

  unidade_busca #(.LARGURA(32), .PROFUNDIDADE(4), .PC_RESET(32'h0000_0000), .PASSO(4)) u_dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_data(mem_data),
    .desvio(desvio), .desvio_alvo(desvio_alvo), .parada(parada),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .ocupacao(ocupacao)
  );

  // Second instance only exercises the address wrap from a high reset PC.
  unidade_busca #(.LARGURA(32), .PROFUNDIDADE(4), .PC_RESET(32'hFFFF_FFF8), .PASSO(4)) u_dut2 (
    .clock(clock), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ready(1'b1), .mem_valid(1'b0), .mem_data(32'h0),
    .desvio(1'b0), .desvio_alvo(32'h0), .parada(1'b0),
    .id_valid(id_valid2), .id_pc(id_pc2), .id_inst(id_inst2), .ocupacao(ocupacao2)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int ciclo = 0;
  int lat_min = 1;
  int lat_max = 1;
  int prob_valid = 100;

  // reference model state
  logic [31:0] pc_m;
  logic [31:0] voo[$];
  int          pronto[$];
  ent_t        fila[$];
  int          descartar_m;
  bit          exp_req, exp_valid;

  function automatic logic [31:0] dado(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %h expected %h", nome, ciclo, act, exp);
    end
  endtask

  // Drive the memory side, then compare every output with the model.
  task automatic ciclo_a();
    @(negedge clock);
    if (reset) begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_data  = $urandom;
    end else if (pronto.size() > 0 && pronto[0] <= ciclo &&
                 int'($urandom_range(1, 100)) <= prob_valid) begin
      mem_valid = 1'b1;
      mem_data  = dado(voo[0]);
    end else begin
      mem_valid = 1'b0;
      mem_data  = $urandom;
    end
    #1;
    exp_req   = !reset && !desvio && (voo.size() + fila.size() < P);
    exp_valid = !reset && (fila.size() > 0);
    chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
    if (!reset) chk("mem_addr", mem_addr, pc_m);
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("id_pc", id_pc, fila[0].pc);
      chk("id_inst", id_inst, fila[0].inst);
    end else begin
      chk("id_pc_zero", id_pc, 32'h0);
      chk("id_inst_zero", id_inst, 32'h0);
    end
    chk("ocupacao", {29'b0, ocupacao}, reset ? 32'h0 : 32'(fila.size()));
  endtask

  // Advance the model with the inputs seen at the clock edge.
  task automatic ciclo_b();
    logic [31:0] a;
    ent_t e;
    @(posedge clock);
    #1;
    a = 32'h0;
    if (reset) begin
      pc_m = PCR;
      voo.delete();
      pronto.delete();
      fila.delete();
      descartar_m = 0;
    end else begin
      if (mem_valid) begin
        a = voo.pop_front();
        void'(pronto.pop_front());
      end
      if (desvio) begin
        fila.delete();
        pc_m = desvio_alvo;
        descartar_m = voo.size();
      end else begin
        if (exp_valid && !parada) void'(fila.pop_front());
        if (mem_valid) begin
          if (descartar_m > 0) begin
            descartar_m--;
          end else begin
            e.pc = a;
            e.inst = mem_data;
            fila.push_back(e);
          end
        end
        if (exp_req && mem_ready) begin
          voo.push_back(pc_m);
          pronto.push_back(ciclo + int'($urandom_range(lat_min, lat_max)));
          pc_m = pc_m + PASSO_M;
        end
      end
    end
    ciclo++;
  endtask

  task automatic um_ciclo();
    ciclo_a();
    ciclo_b();
  endtask

  task automatic aplica_reset(input int n);
    reset = 1'b1;
    desvio = 1'b0;
    parada = 1'b0;
    for (int i = 0; i < n; i++) begin
      ciclo_a();
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_ocupacao", {29'b0, ocupacao}, 32'h0);
      ciclo_b();
    end
    reset = 1'b0;
  endtask

  initial begin
    bit visto;
    pc_m = PCR;
    descartar_m = 0;

    // 1-cycle memory streaming, plus the wrap-around instance
    lat_min = 1; lat_max = 1; prob_valid = 100; mem_ready = 1'b1;
    aplica_reset(2);
    ciclo_a();
    chk("s34_addr0", mem_addr, 32'h0);
    chk("s34_req0", {31'b0, mem_req}, 32'h1);
    chk("s39_addr0", mem_addr2, 32'hFFFF_FFF8);
    ciclo_b();
    ciclo_a();
    chk("s34_addr1", mem_addr, 32'h4);
    chk("s34_valid1", {31'b0, id_valid}, 32'h0);
    chk("s39_addr1", mem_addr2, 32'hFFFF_FFFC);
    ciclo_b();
    ciclo_a();
    chk("s34_valid2", {31'b0, id_valid}, 32'h1);
    chk("s34_idpc2", id_pc, 32'h0);
    chk("s34_idinst2", id_inst, dado(32'h0));
    chk("s34_addr2", mem_addr, 32'h8);
    chk("s39_addr2", mem_addr2, 32'h0);
    ciclo_b();
    ciclo_a();
    chk("s34_idpc3", id_pc, 32'h4);
    ciclo_b();
    repeat (10) um_ciclo();

    // stall fills the queue, release drains it in order
    aplica_reset(1);
    parada = 1'b1;
    repeat (5) um_ciclo();
    ciclo_a();
    chk("s35_ocup", {29'b0, ocupacao}, 32'h4);
    chk("s35_req", {31'b0, mem_req}, 32'h0);
    chk("s35_addr", mem_addr, 32'h10);
    ciclo_b();
    parada = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ciclo_a();
      chk("s35_drain", id_pc, 32'(i * 4));
      if (i == 1) begin
        chk("s35_resume_req", {31'b0, mem_req}, 32'h1);
        chk("s35_resume_addr", mem_addr, 32'h10);
      end
      ciclo_b();
    end
    repeat (10) um_ciclo();

    // redirect with three requests in flight
    aplica_reset(1);
    lat_min = 10; lat_max = 10;
    repeat (3) um_ciclo();
    desvio = 1'b1;
    desvio_alvo = 32'h0000_0100;
    um_ciclo();
    desvio = 1'b0;
    lat_min = 1; lat_max = 1;
    ciclo_a();
    chk("s36_addr", mem_addr, 32'h100);
    chk("s36_valid", {31'b0, id_valid}, 32'h0);
    ciclo_b();
    visto = 1'b0;
    for (int k = 0; k < 40 && !visto; k++) begin
      ciclo_a();
      if (id_valid) begin
        visto = 1'b1;
        chk("s36_first_idpc", id_pc, 32'h100);
      end
      ciclo_b();
    end
    chk("s36_seen", {31'b0, visto}, 32'h1);

    // memory not ready: address held
    aplica_reset(1);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ciclo_a();
      chk("s37_hold", mem_addr, 32'h0);
      ciclo_b();
    end
    mem_ready = 1'b1;
    ciclo_a();
    chk("s37_addr0", mem_addr, 32'h0);
    ciclo_b();
    ciclo_a();
    chk("s37_addr1", mem_addr, 32'h4);
    ciclo_b();

    // reset with a full queue, garbage responses during reset
    parada = 1'b1;
    repeat (8) um_ciclo();
    ciclo_a();
    chk("s38_full", {29'b0, ocupacao}, 32'h4);
    ciclo_b();
    aplica_reset(2);
    ciclo_a();
    chk("s38_valid", {31'b0, id_valid}, 32'h0);
    chk("s38_ocup", {29'b0, ocupacao}, 32'h0);
    chk("s38_addr", mem_addr, PCR);
    ciclo_b();

    // randomized run
    lat_min = 1; lat_max = 4; prob_valid = 70;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      desvio      = !reset && ($urandom_range(0, 24) == 0);
      desvio_alvo = $urandom;
      parada      = ($urandom_range(0, 99) < 30);
      mem_ready   = ($urandom_range(0, 99) < 75);
      um_ciclo();
    end
    reset = 1'b0; desvio = 1'b0; parada = 1'b0; mem_ready = 1'b1;
    repeat (20) um_ciclo();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
